blood_sprite_reader: RTL and testbench

- Reads the 64x64 blood-splatter sprite ROMs. It generates the 6-bit row/col addresses from the VGA pixel position and selects the animation frame ROM.
- It absorbs the ROM's 1-clock registered-address latency and produces a per-pixel colour plus an opaque flag for the pixel mixer.
- A hit trigger starts a one-shot animation. The animation runs through NUM_FRAMES frames, each held for FRAME_HOLD vsync ticks, anchored at a latched screen origin.

---
 rtl/blood_sprite_reader.sv | 182 ++++++++++++++++++
 tb/tb_blood_sprite_reader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/blood_sprite_reader.sv
// Blood-splatter sprite reader: one-shot frame animation FSM, ROM address
// generation and a 2-clock pixel pipeline that absorbs the ROM latency.
//
// Ports:
//   clk, rst_n             pixel clock, async active-low reset
//   trigger                start/restart; samples origin_x/origin_y (and mirror)
//   origin_x, origin_y     sprite top-left corner
//   frame_tick             once-per-frame (vsync) pulse that paces the animation
//   pixel_x, pixel_y       current VGA position; video_on = active region
//   rom_row, rom_col       6-bit ROM address, driven every cycle
//   frame_sel              frame ROM select
//   rom_color              ROM colour, valid 1 clk after the address
//   blood_rgb, blood_on    registered colour / opaque-and-visible flag
//   busy, done             animation running / 1-cycle end-of-animation pulse
//
// Optional feature: define BLOOD_MIRROR_EN to add the `mirror` input, which
// is latched on trigger and flips the sprite horizontally.
module blood_sprite_reader #(
    parameter int          NUM_FRAMES  = 10,
    parameter int          FRAME_HOLD  = 4,
    parameter logic [11:0] TRANSPARENT = 12'h000,
    parameter int          COORD_W     = 10,
    localparam int FS_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
    localparam int HC_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               trigger,
    input  logic [COORD_W-1:0] origin_x,
    input  logic [COORD_W-1:0] origin_y,
`ifdef BLOOD_MIRROR_EN
    input  logic               mirror,
`endif
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] pixel_x,
    input  logic [COORD_W-1:0] pixel_y,
    input  logic               video_on,
    output logic [5:0]         rom_row,
    output logic [5:0]         rom_col,
    output logic [FS_W-1:0]    frame_sel,
    input  logic [11:0]        rom_color,
    output logic [11:0]        blood_rgb,
    output logic               blood_on,
    output logic               busy,
    output logic               done
);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [COORD_W-1:0] org_x_q, org_x_d;
    logic [COORD_W-1:0] org_y_q, org_y_d;
    logic [FS_W-1:0]    frame_sel_q, frame_sel_d;
    logic [HC_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic               done_q, done_d;
    logic               in_box_d1_q, in_box_d1_d;
    logic               blood_on_q, blood_on_d;
    logic [11:0]        blood_rgb_q, blood_rgb_d;
`ifdef BLOOD_MIRROR_EN
    logic               mirror_q, mirror_d;
`endif

    // FSM next state
    always_comb begin
        state_d     = state_q;
        org_x_d     = org_x_q;
        org_y_d     = org_y_q;
        frame_sel_d = frame_sel_q;
        hold_cnt_d  = hold_cnt_q;
        done_d      = 1'b0;
`ifdef BLOOD_MIRROR_EN
        mirror_d    = mirror_q;
`endif
        if (trigger) begin
            // Start or restart; a simultaneous frame_tick is dropped.
            state_d     = PLAY;
            org_x_d     = origin_x;
            org_y_d     = origin_y;
            frame_sel_d = '0;
            hold_cnt_d  = '0;
`ifdef BLOOD_MIRROR_EN
            mirror_d    = mirror;
`endif
        end else begin
            unique case (state_q)
                IDLE: ;
                PLAY: begin
                    if (frame_tick) begin
                        if (hold_cnt_q < HC_W'(FRAME_HOLD - 1)) begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end else begin
                            hold_cnt_d = '0;
                            if (frame_sel_q < FS_W'(NUM_FRAMES - 1)) begin
                                frame_sel_d = frame_sel_q + 1'b1;
                            end else begin
                                frame_sel_d = '0;
                                state_d     = IDLE;
                                done_d      = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Address path: one extra bit so origins near the right/bottom edge
    // cannot wrap the box end back onto small coordinates.
    logic [COORD_W:0] px_w, py_w, ox_w, oy_w, ox_end, oy_end;
    logic [5:0]       dx, dy;
    logic             in_box;

    always_comb begin
        px_w   = {1'b0, pixel_x};
        py_w   = {1'b0, pixel_y};
        ox_w   = {1'b0, org_x_q};
        oy_w   = {1'b0, org_y_q};
        ox_end = ox_w + (COORD_W+1)'(64);
        oy_end = oy_w + (COORD_W+1)'(64);
        dx     = 6'(px_w - ox_w);
        dy     = 6'(py_w - oy_w);
        in_box = (state_q == PLAY) & video_on
               & (px_w >= ox_w) & (px_w < ox_end)
               & (py_w >= oy_w) & (py_w < oy_end);
    end

    assign rom_row = dy;
`ifdef BLOOD_MIRROR_EN
    assign rom_col = mirror_q ? (6'd63 - dx) : dx;
`else
    assign rom_col = dx;
`endif

    // Pipeline: stage 1 aligns in_box with the ROM's registered address,
    // stage 2 qualifies the returned colour.
    always_comb begin
        in_box_d1_d = in_box;
        blood_on_d  = in_box_d1_q & (rom_color != TRANSPARENT);
        blood_rgb_d = blood_on_d ? rom_color : 12'h000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            org_x_q     <= '0;
            org_y_q     <= '0;
            frame_sel_q <= '0;
            hold_cnt_q  <= '0;
            done_q      <= 1'b0;
            in_box_d1_q <= 1'b0;
            blood_on_q  <= 1'b0;
            blood_rgb_q <= 12'h000;
`ifdef BLOOD_MIRROR_EN
            mirror_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            org_x_q     <= org_x_d;
            org_y_q     <= org_y_d;
            frame_sel_q <= frame_sel_d;
            hold_cnt_q  <= hold_cnt_d;
            done_q      <= done_d;
            in_box_d1_q <= in_box_d1_d;
            blood_on_q  <= blood_on_d;
            blood_rgb_q <= blood_rgb_d;
`ifdef BLOOD_MIRROR_EN
            mirror_q    <= mirror_d;
`endif
        end
    end

    assign frame_sel = frame_sel_q;
    assign busy      = (state_q == PLAY);
    assign done      = done_q;
    assign blood_on  = blood_on_q;
    assign blood_rgb = blood_rgb_q;

endmodule

// File: tb/tb_blood_sprite_reader.sv
// Testbench for blood_sprite_reader: scoreboard on the pixel pipeline plus
// direct checks of addresses, frame sequencing, retrigger and reset.
module tb_blood_sprite_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trigger = 1'b0;
    logic [9:0] origin_x = '0;
    logic [9:0] origin_y = '0;
`ifdef BLOOD_MIRROR_EN
    logic       mirror = 1'b0;
`endif
    logic       frame_tick = 1'b0;
    logic [9:0] pixel_x = '0;
    logic [9:0] pixel_y = '0;
    logic       video_on = 1'b0;
    logic [5:0] rom_row, rom_col;
    logic [3:0] frame_sel;
    logic [11:0] rom_color = '0;
    logic [11:0] blood_rgb;
    logic       blood_on, busy, done;

    blood_sprite_reader dut (
        .clk(clk), .rst_n(rst_n), .trigger(trigger),
        .origin_x(origin_x), .origin_y(origin_y),
`ifdef BLOOD_MIRROR_EN
        .mirror(mirror),
`endif
        .frame_tick(frame_tick),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .rom_row(rom_row), .rom_col(rom_col), .frame_sel(frame_sel),
        .rom_color(rom_color), .blood_rgb(blood_rgb),
        .blood_on(blood_on), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // ROM model: registered address, returns the colour set with the pixel.
    logic [11:0] fill_color = '0;
    always @(posedge clk) rom_color <= fill_color;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic        on;
        logic [11:0] rgb;
        int          due;
    } sb_t;
    sb_t sb[$];

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            sb_t e;
            e = sb.pop_front();
            chk("blood_on", 32'(blood_on), 32'(e.on));
            chk("blood_rgb", 32'(blood_rgb), 32'(e.rgb));
        end
    end

    int  m_ox = 0, m_oy = 0;
    bit  m_busy = 0;

    task automatic drive_px(input int x, input int y, input bit von,
                            input logic [11:0] col);
        sb_t e;
        bit  box;
        @(negedge clk);
        pixel_x    = 10'(x);
        pixel_y    = 10'(y);
        video_on   = von;
        fill_color = col;
        box = m_busy && von && x >= m_ox && x < m_ox + 64
              && y >= m_oy && y < m_oy + 64;
        e.on  = box && (col != 12'h000);
        e.rgb = e.on ? col : 12'h000;
        e.due = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic flush();
        repeat (3) drive_px(0, 0, 0, 12'h000);
    endtask

    task automatic do_trig(input int x, input int y, input bit tick);
        @(negedge clk);
        trigger    = 1'b1;
        frame_tick = tick;
        origin_x   = 10'(x);
        origin_y   = 10'(y);
        @(negedge clk);
        trigger    = 1'b0;
        frame_tick = 1'b0;
        m_ox = x;
        m_oy = y;
        m_busy = 1;
    endtask

    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_on", 32'(blood_on), 0);
        chk("rst_frame", 32'(frame_sel), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Pixel pipeline, origin (100,200)
        do_trig(100, 200, 0);
        chk("busy_trig", 32'(busy), 1);
        drive_px(130, 239, 1, 12'hE00);
        #1;
        chk("row_130_239", 32'(rom_row), 39);
        chk("col_130_239", 32'(rom_col), 30);
        drive_px(120, 210, 1, 12'h000);
        drive_px(164, 200, 1, 12'hE00);
        drive_px(163, 263, 1, 12'h0AB);
        drive_px(99, 200, 1, 12'h123);
        drive_px(110, 220, 0, 12'h456);
        drive_px(100, 264, 1, 12'h789);
        drive_px(101, 201, 1, 12'hFFF);
        flush();

        // 40 ticks: frame_sel every 4th, done on the 40th
        for (int k = 1; k <= 40; k++) begin
            tick();
            chk($sformatf("frame_t%0d", k), 32'(frame_sel),
                (k == 40) ? 0 : k / 4);
            chk($sformatf("done_t%0d", k), 32'(done), (k == 40) ? 1 : 0);
            chk($sformatf("busy_t%0d", k), 32'(busy), (k == 40) ? 0 : 1);
        end
        m_busy = 0;
        @(negedge clk);
        chk("done_drop", 32'(done), 0);
        drive_px(130, 239, 1, 12'hE00);
        flush();

        // Retrigger at frame 6 coincident with a tick
        do_trig(5, 5, 0);
        repeat (26) tick();
        chk("frame6", 32'(frame_sel), 6);
        do_trig(0, 0, 1);
        chk("retrig_frame", 32'(frame_sel), 0);
        chk("retrig_done", 32'(done), 0);
        chk("retrig_busy", 32'(busy), 1);
        drive_px(7, 9, 1, 12'h0F0);
        #1;
        chk("row_7_9", 32'(rom_row), 9);
        chk("col_7_9", 32'(rom_col), 7);
        flush();
        repeat (3) tick();
        chk("hold_reset", 32'(frame_sel), 0);
        tick();
        chk("hold_adv", 32'(frame_sel), 1);

        // Origin near the right edge: no wrap
        do_trig(1000, 50, 0);
        drive_px(5, 60, 1, 12'hFFF);
        #1;
        chk("col_wrap", 32'(rom_col), 29);
        chk("row_wrap", 32'(rom_row), 10);
        drive_px(1010, 60, 1, 12'hABC);
        drive_px(1023, 113, 1, 12'h321);
        flush();

`ifdef BLOOD_MIRROR_EN
        mirror = 1'b1;
        do_trig(100, 50, 0);
        mirror = 1'b0;
        drive_px(110, 60, 1, 12'h555);
        #1;
        chk("mir_col", 32'(rom_col), 53);
        chk("mir_row", 32'(rom_row), 10);
        flush();
`endif

        // Reset mid-play at frame 3
        do_trig(20, 20, 0);
        repeat (12) tick();
        chk("pre_rst_frame", 32'(frame_sel), 3);
        #2;
        rst_n = 1'b0;
        m_busy = 0;
        #1;
        chk("arst_frame", 32'(frame_sel), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_on", 32'(blood_on), 0);
        chk("arst_rgb", 32'(blood_rgb), 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_trig(30, 30, 0);
        chk("post_rst_frame", 32'(frame_sel), 0);
        chk("post_rst_busy", 32'(busy), 1);
        repeat (4) tick();
        chk("post_rst_adv", 32'(frame_sel), 1);
        drive_px(40, 40, 1, 12'h0E0);
        flush();

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
